dmni_send: RTL and testbench

DMNI_SEND -- requirements
Module: dmni_send

---
 rtl/dmni_send_pkg.sv | 13 +
 rtl/dmni_send_fifo.sv | 54 +++++
 rtl/dmni_send.sv | 127 ++++++++++++
 tb/tb_dmni_send.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmni_send_pkg.sv
// Shared types and constants for the DMNI send path.
package DMNIPkg;

    typedef enum logic [1:0] {
        IDLE,
        SEG1,
        SEG2,
        DRAIN
    } send_state_e;

    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/dmni_send_fifo.sv
// Flit FIFO for the DMNI send path; power-of-two depth, no data reset.
module dmni_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmni_send.sv
// DMNI send engine: streams two memory segments as one packet into the
// router local port, with read issue throttled by FIFO space.
module dmni_send
    import DMNIPkg::*;
#(
    parameter int BUFFER_SIZE = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] size_i,
    input  logic [31:0] address_i,
    input  logic [31:0] size_2_i,
    input  logic [31:0] address_2_i,
    output logic        active_o,
    output logic        mem_en_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        noc_tx_o,
    input  logic        noc_credit_i,
    output logic [31:0] noc_data_o,
    output logic        noc_eop_o
);

    localparam int CW = $clog2(BUFFER_SIZE) + 1;

    send_state_e state;
    logic [31:0] cnt;
    logic [31:0] addr;
    logic [31:0] size2_q;
    logic [31:0] addr2_q;
    logic [31:0] total;
    logic [31:0] sent;
    logic        inflight;

    logic [CW-1:0] occ;
    logic [CW:0]   pending;
    logic [31:0]   head;
    logic          full;
    logic          empty;
    logic          issue;
    logic          xfer;
    logic          last;

    dmni_fifo #(
        .DEPTH (BUFFER_SIZE),
        .WIDTH (32)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (inflight),
        .wdata  (mem_data_i),
        .pop    (xfer),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (occ)
    );

    // In-flight reads count against FIFO space so returned data always fits.
    assign pending = {1'b0, occ} + {{CW{1'b0}}, inflight};
    assign issue   = (state == SEG1 || state == SEG2) && (cnt != '0)
                     && !full && (pending < (CW+1)'(BUFFER_SIZE));
    assign xfer    = !empty && noc_credit_i;
    assign last    = (sent + 32'd1 == total);

    assign active_o   = (state != IDLE);
    assign mem_en_o   = issue;
    assign mem_addr_o = addr;
    assign noc_tx_o   = !empty;
    assign noc_data_o = empty ? '0 : head;
    assign noc_eop_o  = !empty && last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            size2_q  <= '0;
            addr2_q  <= '0;
            total    <= '0;
            sent     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (xfer) sent <= sent + 32'd1;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= SEG1;
                        cnt     <= size_i;
                        addr    <= address_i;
                        size2_q <= size_2_i;
                        addr2_q <= address_2_i;
                        total   <= size_i + size_2_i;
                        sent    <= '0;
                    end
                end
                SEG1: begin
                    if (cnt == '0 || (issue && cnt == 32'd1)) begin
                        state <= SEG2;
                        cnt   <= size2_q;
                        addr  <= addr2_q;
                    end else if (issue) begin
                        cnt  <= cnt - 32'd1;
                        addr <= addr + WORD_STRIDE;
                    end
                end
                SEG2: begin
                    if (issue) begin
                        cnt  <= cnt - 32'd1;
                        addr <= addr + WORD_STRIDE;
                    end
                    if (cnt == '0 || (issue && cnt == 32'd1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (total == '0 || (xfer && last)) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmni_send.sv
// Bench for dmni_send: directed cases plus random packets against a queue model.
module tb_dmni_send;

    localparam int BS = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] size_i = '0;
    logic [31:0] address_i = '0;
    logic [31:0] size_2_i = '0;
    logic [31:0] address_2_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        noc_credit_i = 1'b0;
    logic        active_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic        noc_tx_o;
    logic [31:0] noc_data_o;
    logic        noc_eop_o;

    dmni_send #(.BUFFER_SIZE(BS)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .size_i       (size_i),
        .address_i    (address_i),
        .size_2_i     (size_2_i),
        .address_2_i  (address_2_i),
        .active_o     (active_o),
        .mem_en_o     (mem_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .noc_tx_o     (noc_tx_o),
        .noc_credit_i (noc_credit_i),
        .noc_data_o   (noc_data_o),
        .noc_eop_o    (noc_eop_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_eop[$];

    bit          pend_en;
    logic [31:0] pend_addr;
    bit          hold;
    logic [31:0] hold_data;
    logic        hold_eop;
    int          issued, sent, act_cycles, tx_cycles, credit_pct;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Packet model: every word of seg1 then seg2, eop on the final one.
    task automatic load(input int sz, input logic [31:0] ad,
                        input int sz2, input logic [31:0] ad2);
        logic [31:0] a;
        for (int i = 0; i < sz + sz2; i++) begin
            a = (i < sz) ? ad + 32'(i) * 4 : ad2 + 32'(i - sz) * 4;
            exp_addr.push_back(a);
            exp_data.push_back(hash(a));
            exp_eop.push_back(1'b0);
        end
        if (exp_eop.size() > 0) exp_eop[exp_eop.size() - 1] = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk_i);
        mem_data_i   = pend_en ? hash(pend_addr) : $urandom;
        noc_credit_i = ($urandom_range(99) < credit_pct);
        if (hold) begin
            chk("hold_data", noc_data_o, hold_data);
            chk("hold_eop", 32'(noc_eop_o), 32'(hold_eop));
        end
        if (mem_en_o) begin
            issued++;
            if (exp_addr.size() == 0) chk("spurious_read", 32'(mem_en_o), 0);
            else chk("read_addr", mem_addr_o, exp_addr.pop_front());
            chk("occupancy_bound", 32'((issued - sent) <= BS), 1);
        end
        pend_en   = mem_en_o;
        pend_addr = mem_addr_o;
        if (noc_tx_o && noc_credit_i) begin
            sent++;
            if (exp_data.size() == 0) begin
                chk("spurious_flit", 32'(noc_tx_o), 0);
            end else begin
                chk("flit_data", noc_data_o, exp_data.pop_front());
                chk("flit_eop", 32'(noc_eop_o), 32'(exp_eop.pop_front()));
            end
        end
        hold      = noc_tx_o && !noc_credit_i;
        hold_data = noc_data_o;
        hold_eop  = noc_eop_o;
        if (active_o) act_cycles++;
        if (noc_tx_o) tx_cycles++;
    endtask

    task automatic start_txn(input int sz, input logic [31:0] ad,
                             input int sz2, input logic [31:0] ad2);
        issued = 0; sent = 0; act_cycles = 0; tx_cycles = 0;
        load(sz, ad, sz2, ad2);
        size_i = 32'(sz); address_i = ad;
        size_2_i = 32'(sz2); address_2_i = ad2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        size_i = $urandom; address_i = $urandom;
        size_2_i = $urandom; address_2_i = $urandom;
    endtask

    task automatic run_txn(input int sz, input logic [31:0] ad,
                           input int sz2, input logic [31:0] ad2,
                           input int pct, input int zero_n, input bit mid);
        int n;
        credit_pct = (zero_n > 0) ? 0 : pct;
        start_txn(sz, ad, sz2, ad2);
        n = 0;
        while ((active_o || exp_data.size() != 0) && n < 500) begin
            if (zero_n > 0 && n == zero_n) begin
                chk("stall_reads", 32'(issued), BS);
                chk("stall_tx", 32'(noc_tx_o), 1);
                chk("stall_sent", 32'(sent), 0);
            end
            credit_pct = (n < zero_n) ? 0 : pct;
            if (mid && n == 2) begin
                start_i = 1'b1; size_i = 32'd7; size_2_i = 32'd2;
                address_i = 32'h9000; address_2_i = 32'hA000;
            end
            tick();
            start_i = 1'b0;
            n++;
        end
        chk("txn_timeout", 32'(n < 500), 1);
        chk("reads_left", 32'(exp_addr.size()), 0);
        chk("flits_left", 32'(exp_data.size()), 0);
        chk("flit_count", 32'(sent), 32'(sz + sz2));
        chk("idle_after", 32'(active_o), 0);
        hold = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_active"}, 32'(active_o), 0);
        chk({tag, "_mem_en"}, 32'(mem_en_o), 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_tx"}, 32'(noc_tx_o), 0);
        chk({tag, "_data"}, noc_data_o, 0);
        chk({tag, "_eop"}, 32'(noc_eop_o), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sz, sz2;
        pend_en = 0; hold = 0; credit_pct = 100;
        #1 rst_ni = 1'b0;
        #2 chk_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Two segments, full credit.
        run_txn(3, 32'h100, 2, 32'h800, 100, 0, 0);

        // Credit withheld: reads stop at FIFO depth, head stays put.
        run_txn(4, 32'h1000, 0, 32'h0, 100, 20, 0);

        // Empty packet: three active cycles, nothing else.
        run_txn(0, 32'h40, 0, 32'h80, 100, 0, 0);
        chk("empty_active", 32'(act_cycles), 3);
        chk("empty_reads", 32'(issued), 0);
        chk("empty_tx", 32'(tx_cycles), 0);

        // Second start mid-send must be ignored.
        run_txn(5, 32'h500, 3, 32'h600, 60, 0, 1);

        // Address wrap.
        run_txn(2, 32'hFFFF_FFFC, 0, 32'h0, 100, 0, 0);

        // Reset with two flits buffered and a read in flight.
        credit_pct = 0;
        start_txn(5, 32'h2000, 0, 32'h0);
        n = 0;
        while (issued < 3 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_setup", 32'(issued >= 3), 1);
        tick();
        #2 rst_ni = 1'b0;
        #1 chk_zero("async_reset");
        exp_addr.delete(); exp_data.delete(); exp_eop.delete();
        pend_en = 0; hold = 0;
        @(negedge clk_i);
        chk_zero("held_reset");
        rst_ni = 1'b1;
        run_txn(3, 32'h3000, 1, 32'h4000, 100, 0, 0);

        // Random packets and credit patterns.
        for (int t = 0; t < 12; t++) begin
            sz  = $urandom_range(0, 6);
            sz2 = $urandom_range(0, 6);
            run_txn(sz, $urandom & 32'hFFFF_FFFC, sz2,
                    $urandom & 32'hFFFF_FFFC, $urandom_range(20, 100),
                    (t % 4 == 3) ? 6 : 0, 1'(t % 5 == 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
